// File: rtl/if_fetch_buf_if.sv
// Fetch-stage bundle: redirect input, IMEM request/response and the decode-side valid/ready port.
// The master modport belongs to the fetch stage and the slave modport to its environment.
interface if_fetch_buf_if #(
    parameter int FETCH_WIDTH = 2,
    parameter int INSTR_W     = 32,
    parameter int ADDR_W      = 32
);
    logic                           redirect_valid;
    logic [ADDR_W-1:0]              redirect_pc;
    logic                           imem_req;
    logic [ADDR_W-1:0]              imem_addr;
    logic [FETCH_WIDTH*INSTR_W-1:0] imem_rdata;
    logic                           out_valid;
    logic                           out_ready;
    logic [ADDR_W-1:0]              out_pc;
    logic [FETCH_WIDTH*INSTR_W-1:0] out_instr;
    logic [FETCH_WIDTH-1:0]         out_mask;

    modport master (
        input  redirect_valid, redirect_pc, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_pc, out_instr, out_mask
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_pc, out_instr, out_mask
    );
endinterface

// File: rtl/if_fetch_buf.sv
// Multi-wide fetch stage with a DEPTH-group fetch buffer between IMEM and decode.
// Defining IF_PERF_CNT_EN adds saturating perf_groups/perf_stall/perf_flush counters.
module if_fetch_buf #(
    parameter int                FETCH_WIDTH = 2,
    parameter int                DEPTH       = 4,
    parameter int                INSTR_W     = 32,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0000_1000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 FREEZE,
    if_fetch_buf_if.master       bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]          perf_groups,
    output logic [31:0]          perf_stall,
    output logic [31:0]          perf_flush
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam int CW1   = CW + 1;
    localparam int DW    = FETCH_WIDTH * INSTR_W;
    localparam logic [ADDR_W-1:0] GRP     = ADDR_W'(FETCH_WIDTH * 4);
    localparam logic [CW:0]       DEPTH_L = CW1'(DEPTH);

    logic [ADDR_W-1:0]      r_pc;
    logic [CW-1:0]          r_count;
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic                   r_inflight;
    logic                   r_kill;
    logic [ADDR_W-1:0]      r_tag_pc;
    logic [FETCH_WIDTH-1:0] r_tag_mask;

    logic [ADDR_W-1:0]      r_buf_pc    [DEPTH];
    logic [DW-1:0]          r_buf_instr [DEPTH];
    logic [FETCH_WIDTH-1:0] r_buf_mask  [DEPTH];

    logic [ADDR_W-1:0]      w_faddr;
    logic [ADDR_W-1:0]      w_falign;
    logic [ADDR_W-1:0]      w_off;
    logic [FETCH_WIDTH-1:0] w_fmask;
    logic [CW:0]            w_used;
    logic                   w_issue;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_valid;
    logic [DW-1:0]          w_wdata;

    // A redirect flushes everything, so a redirect cycle always has room to issue.
    always_comb begin
        w_faddr  = bus.redirect_valid ? bus.redirect_pc : r_pc;
        w_falign = w_faddr & ~(GRP - ADDR_W'(1));
        w_off    = (w_faddr & (GRP - ADDR_W'(1))) >> 2;
        w_fmask  = {FETCH_WIDTH{1'b1}} << w_off;
        w_used   = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
        w_issue  = !RESET && !FREEZE && (bus.redirect_valid || (w_used < DEPTH_L));
        w_valid  = (r_count != '0);
        w_push   = r_inflight && !r_kill && !bus.redirect_valid;
        w_pop    = w_valid && bus.out_ready && !FREEZE && !bus.redirect_valid;
        w_wdata  = '0;
        for (int s = 0; s < FETCH_WIDTH; s++) begin
            w_wdata[s*INSTR_W +: INSTR_W] = r_tag_mask[s] ? bus.imem_rdata[s*INSTR_W +: INSTR_W] : '0;
        end
    end

    assign bus.imem_req  = w_issue;
    assign bus.imem_addr = w_falign;
    assign bus.out_valid = w_valid;
    assign bus.out_pc    = w_valid ? r_buf_pc[r_head]    : '0;
    assign bus.out_instr = w_valid ? r_buf_instr[r_head] : '0;
    assign bus.out_mask  = w_valid ? r_buf_mask[r_head]  : '0;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pc       <= RESET_PC;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
            r_tag_pc   <= '0;
            r_tag_mask <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_pc[i]    <= '0;
                r_buf_instr[i] <= '0;
                r_buf_mask[i]  <= '0;
            end
        end else begin
            if (bus.redirect_valid) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_buf_pc[r_tail]    <= r_tag_pc;
                    r_buf_instr[r_tail] <= w_wdata;
                    r_buf_mask[r_tail]  <= r_tag_mask;
                    r_tail              <= r_tail + PTR_W'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - CW'(1);
                end
            end

            if (w_issue) begin
                r_pc       <= w_falign + GRP;
                r_tag_pc   <= w_falign;
                r_tag_mask <= w_fmask;
            end else if (bus.redirect_valid) begin
                r_pc <= bus.redirect_pc;
            end

            // Every request is answered the next cycle, so inflight simply trails issue.
            r_inflight <= w_issue;
            r_kill     <= bus.redirect_valid && r_inflight && !w_issue;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_groups;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_perf_groups <= '0;
            r_perf_stall  <= '0;
            r_perf_flush  <= '0;
        end else begin
            if (w_pop && (r_perf_groups != '1)) begin
                r_perf_groups <= r_perf_groups + 32'd1;
            end
            if (!w_issue && !FREEZE && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (bus.redirect_valid && (r_perf_flush != '1)) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_groups = r_perf_groups;
    assign perf_stall  = r_perf_stall;
    assign perf_flush  = r_perf_flush;
`endif
endmodule

// File: tb/tb_if_fetch_buf.sv
// Directed testbench for if_fetch_buf (FETCH_WIDTH=2, DEPTH=4) with an address-based IMEM model.
module tb_if_fetch_buf;
    localparam int FW    = 2;
    localparam int DEPTH = 4;
    localparam int IW    = 32;
    localparam int AW    = 32;
    localparam logic [31:0] KEY = 32'hC0DE_0000;

    logic CLK = 1'b0;
    logic RESET;
    logic FREEZE;

    int checkCount  = 0;
    int errorCount  = 0;
    int issueCount  = 0;
    int popCount    = 0;
    int stallCount  = 0;
    int flushCount  = 0;

    if_fetch_buf_if #(.FETCH_WIDTH(FW), .INSTR_W(IW), .ADDR_W(AW)) bus ();

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_groups;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
`endif

    if_fetch_buf #(
        .FETCH_WIDTH(FW), .DEPTH(DEPTH), .INSTR_W(IW), .ADDR_W(AW), .RESET_PC(32'h0000_1000)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .FREEZE(FREEZE),
        .bus(bus)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_groups(perf_groups),
        .perf_stall(perf_stall),
        .perf_flush(perf_flush)
`endif
    );

    always #5 CLK = ~CLK;

    // IMEM model: slot k of a group holds (address of slot k) ^ KEY, one cycle after the request.
    always @(posedge CLK) begin
        bus.imem_rdata <= {(bus.imem_addr + 32'd4) ^ KEY, bus.imem_addr ^ KEY};
    end

    function automatic logic [63:0] grp(input logic [31:0] a, input logic [1:0] m);
        logic [31:0] s0;
        logic [31:0] s1;
        s0 = m[0] ? (a ^ KEY) : 32'd0;
        s1 = m[1] ? ((a + 32'd4) ^ KEY) : 32'd0;
        return {s1, s0};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy, input logic frz);
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.out_ready      = rdy;
        FREEZE             = frz;
    endtask

    task automatic clearCounts();
        issueCount = 0;
        popCount   = 0;
        stallCount = 0;
        flushCount = 0;
    endtask

    // Tallies what the current cycle will do, then advances to just after the next edge.
    task automatic stepCycle();
        #1;
        if (bus.imem_req) issueCount++;
        if (bus.redirect_valid) flushCount++;
        if (bus.out_valid && bus.out_ready && !FREEZE && !bus.redirect_valid) popCount++;
        if (!bus.imem_req && !RESET && !FREEZE) stallCount++;
        @(posedge CLK);
        #2;
    endtask

    task automatic resetDut(input logic rdy);
        RESET = 1'b1;
        applyStimulus(1'b0, 32'd0, rdy, 1'b0);
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        clearCounts();
        #1;
    endtask

    initial begin
        RESET = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        @(posedge CLK);
        #2;
        checkOutput("rst_req",   64'(bus.imem_req),  64'd0);
        checkOutput("rst_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_pc",    64'(bus.out_pc),    64'd0);

        // Streaming from reset release
        RESET = 1'b0;
        clearCounts();
        #1;
        checkOutput("t1_req0",  64'(bus.imem_req),  64'd1);
        checkOutput("t1_addr0", 64'(bus.imem_addr), 64'h1000);
        stepCycle();
        checkOutput("t1_addr1",  64'(bus.imem_addr), 64'h1008);
        checkOutput("t1_valid1", 64'(bus.out_valid), 64'd0);
        stepCycle();
        checkOutput("t1_addr2",  64'(bus.imem_addr), 64'h1010);
        checkOutput("t1_valid2", 64'(bus.out_valid), 64'd1);
        checkOutput("t1_pc2",    64'(bus.out_pc),    64'h1000);
        checkOutput("t1_mask2",  64'(bus.out_mask),  64'h3);
        checkOutput("t1_instr2", bus.out_instr,      grp(32'h1000, 2'b11));
        stepCycle();
        checkOutput("t1_pc3",    64'(bus.out_pc),    64'h1008);

        // Backpressure: credits stop issue at DEPTH groups
        resetDut(1'b0);
        repeat (6) stepCycle();
        checkOutput("t2_issues4", 64'(issueCount),    64'd4);
        checkOutput("t2_reqfull", 64'(bus.imem_req),  64'd0);
        checkOutput("t2_head",    64'(bus.out_pc),    64'h1000);
        bus.out_ready = 1'b1;
        stepCycle();
        bus.out_ready = 1'b0;
        #1;
        checkOutput("t2_head1",   64'(bus.out_pc),    64'h1008);
        checkOutput("t2_req1",    64'(bus.imem_req),  64'd1);
        checkOutput("t2_addr1",   64'(bus.imem_addr), 64'h1020);
        repeat (4) stepCycle();
        checkOutput("t2_issues5", 64'(issueCount),    64'd5);
        checkOutput("t2_reqfull2", 64'(bus.imem_req), 64'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2_order", 64'(bus.out_pc), 64'(32'h1008 + 32'(i * 8)));
            stepCycle();
        end

        // Redirect while a response is in flight
        resetDut(1'b0);
        stepCycle();
        applyStimulus(1'b1, 32'h2004, 1'b0, 1'b0);
        #1;
        checkOutput("t3_req",   64'(bus.imem_req),  64'd1);
        checkOutput("t3_addr",  64'(bus.imem_addr), 64'h2000);
        stepCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        #1;
        checkOutput("t3_empty", 64'(bus.out_valid), 64'd0);
        checkOutput("t3_addr2", 64'(bus.imem_addr), 64'h2008);
        stepCycle();
        checkOutput("t3_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("t3_pc",    64'(bus.out_pc),    64'h2000);
        checkOutput("t3_mask",  64'(bus.out_mask),  64'h2);
        checkOutput("t3_instr", bus.out_instr,      grp(32'h2000, 2'b10));
        bus.out_ready = 1'b1;
        stepCycle();
        checkOutput("t3_pc2",    64'(bus.out_pc),   64'h2008);
        checkOutput("t3_mask2",  64'(bus.out_mask), 64'h3);
        checkOutput("t3_instr2", bus.out_instr,     grp(32'h2008, 2'b11));

        // FREEZE for 3 cycles with a response in flight
        FREEZE = 1'b1;
        issueCount = 0;
        #1;
        checkOutput("t4_req", 64'(bus.imem_req), 64'd0);
        stepCycle();
        stepCycle();
        checkOutput("t4_hold", 64'(bus.out_pc), 64'h2008);
        stepCycle();
        FREEZE = 1'b0;
        #1;
        checkOutput("t4_noissue", 64'(issueCount),    64'd0);
        checkOutput("t4_head",    64'(bus.out_pc),    64'h2008);
        checkOutput("t4_req2",    64'(bus.imem_req),  64'd1);
        checkOutput("t4_addr",    64'(bus.imem_addr), 64'h2018);
        stepCycle();
        checkOutput("t4_pc1", 64'(bus.out_pc), 64'h2010);
        stepCycle();
        checkOutput("t4_pc2", 64'(bus.out_pc), 64'h2018);

        // Redirect during FREEZE: no request, pc still reloaded, in-flight response dropped
        applyStimulus(1'b1, 32'h3000, 1'b1, 1'b1);
        #1;
        checkOutput("t5_req", 64'(bus.imem_req), 64'd0);
        stepCycle();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        #1;
        checkOutput("t5_empty", 64'(bus.out_valid), 64'd0);
        checkOutput("t5_addr",  64'(bus.imem_addr), 64'h3000);
        checkOutput("t5_req2",  64'(bus.imem_req),  64'd1);
        stepCycle();
        checkOutput("t5_empty2", 64'(bus.out_valid), 64'd0);
        stepCycle();
        checkOutput("t5_pc",   64'(bus.out_pc),   64'h3000);
        checkOutput("t5_mask", 64'(bus.out_mask), 64'h3);

        // PC wrap at the top of the address space
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        #1;
        checkOutput("t6_addr", 64'(bus.imem_addr), 64'hFFFF_FFF8);
        stepCycle();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        #1;
        checkOutput("t6_wrap", 64'(bus.imem_addr), 64'h0);
        stepCycle();
        checkOutput("t6_pc",    64'(bus.out_pc),   64'hFFFF_FFF8);
        checkOutput("t6_mask",  64'(bus.out_mask), 64'h2);
        checkOutput("t6_instr", bus.out_instr,     grp(32'hFFFF_FFF8, 2'b10));

`ifdef IF_PERF_CNT_EN
        checkOutput("perf_groups", 64'(perf_groups), 64'(popCount));
        checkOutput("perf_flush",  64'(perf_flush),  64'(flushCount));
        checkOutput("perf_stall",  64'(perf_stall),  64'(stallCount));
`endif

        // Asynchronous reset in the middle of a cycle with three groups buffered
        resetDut(1'b0);
        repeat (4) stepCycle();
        checkOutput("t7_pre", 64'(bus.out_valid), 64'd1);
        #3;
        RESET = 1'b1;
        #1;
        checkOutput("t7_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("t7_req",   64'(bus.imem_req),  64'd0);
        checkOutput("t7_pc",    64'(bus.out_pc),    64'd0);
        stepCycle();
        RESET = 1'b0;
        #1;
        checkOutput("t7_addr",  64'(bus.imem_addr), 64'h1000);
        checkOutput("t7_req2",  64'(bus.imem_req),  64'd1);
        checkOutput("t7_empty", 64'(bus.out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
